// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared types and constants for the CU read-command arbiter slice:
// command/response buffer lines, buffer status, CU ID allocation and
// the debug view of the arbiter's outstanding counters.
package cu_read_command_arbiter_pkg;

    localparam int NUM_READ_REQUESTERS  = 4;
    localparam int READ_FIFO_DEPTH      = 4;
    localparam int MAX_READ_OUTSTANDING = 16;

    localparam int CU_ID_W    = 8;
    localparam int TAG_W      = 8;
    localparam int ADDR_W     = 32;
    localparam int READ_IDX_W = $clog2(NUM_READ_REQUESTERS);
    localparam int READ_CNT_W = $clog2(MAX_READ_OUTSTANDING + 1);

    // CU IDs are allocated so the low READ_IDX_W bits name the read port.
    localparam logic [CU_ID_W-1:0] CU_ID_DATA_READ   = 8'h20;
    localparam logic [CU_ID_W-1:0] CU_ID_EDGE_READ   = 8'h21;
    localparam logic [CU_ID_W-1:0] CU_ID_VERTEX_READ = 8'h22;
    localparam logic [CU_ID_W-1:0] CU_ID_AUX_READ    = 8'h23;

    typedef struct packed {
        logic               valid;
        logic [CU_ID_W-1:0] cu_id;
        logic [TAG_W-1:0]   tag;
        logic [ADDR_W-1:0]  address;
    } CommandBufferLine;

    typedef struct packed {
        logic               valid;
        logic [CU_ID_W-1:0] cu_id;
        logic [TAG_W-1:0]   tag;
        logic [1:0]         response;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;

    // Debug view: per-requester in-flight counters plus the round-robin pointer.
    typedef struct packed {
        logic [NUM_READ_REQUESTERS-1:0][READ_CNT_W-1:0] outstanding;
        logic [READ_IDX_W-1:0]                          rr_ptr;
    } ReadArbiterStatus;

    // Requester index carried in the low bits of a CU ID (num_requesters is a power of two).
    function automatic logic [CU_ID_W-1:0] cu_id_to_requester(input logic [CU_ID_W-1:0] cu_id,
                                                              input int num_requesters);
        return cu_id & CU_ID_W'(num_requesters - 1);
    endfunction

endpackage

// File: rtl/cu_read_command_fifo.sv
// Per-requester command FIFO. Head is shown combinationally; status flags
// are registered from the next-state count so they track the stored count.
// A push while full is dropped and flagged, unless a pop frees a slot on the
// same edge.
module cu_read_command_fifo
    import cu_read_command_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push_in,
    input  CommandBufferLine data_in,
    input  logic             pop_in,
    output CommandBufferLine data_out,
    output logic [CNT_W-1:0] count_out,
    output BufferStatus      status_out,
    output logic             overflow_out
);

    localparam int PTR_W = $clog2(DEPTH);

    CommandBufferLine   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    BufferStatus        status_q, status_d;
    logic               do_push, do_pop;

    assign do_pop       = pop_in && (count_q != '0);
    assign do_push      = push_in && ((count_q != CNT_W'(DEPTH)) || do_pop);
    assign overflow_out = push_in && !do_push;

    // Next count and the status flags derived from it.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        status_d.alfull = (count_d >= CNT_W'(DEPTH - 2));
        status_d.full   = (count_d == CNT_W'(DEPTH));
        status_d.empty  = (count_d == '0);
    end

    // Pointers, count and status flags.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    // Storage array; contents are only read when the count says they are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out   = mem_q[rd_ptr_q];
    assign count_out  = count_q;
    assign status_out = status_q;

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Shares one read-command buffer between several read engines: a private
// FIFO per requester, round-robin issue of one command per cycle, a cap on
// in-flight reads per requester, and response routing by cu_id.
module cu_read_command_arbiter
    import cu_read_command_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS  = NUM_READ_REQUESTERS,
    parameter int FIFO_DEPTH      = READ_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = MAX_READ_OUTSTANDING
) (
    input  logic                                  clock,
    input  logic                                  rstn,
    input  logic                                  enabled_in,
    input  CommandBufferLine [NUM_REQUESTERS-1:0] command_in,
    input  BufferStatus                           command_buffer_status_in,
    input  ResponseBufferLine                     response_in,
    output CommandBufferLine                      command_out,
    output BufferStatus [NUM_REQUESTERS-1:0]      requester_status_out,
    output ResponseBufferLine [NUM_REQUESTERS-1:0] response_out,
    output logic                                  outstanding_idle_out,
    output logic [NUM_REQUESTERS-1:0]             error_out,
    output ReadArbiterStatus                      arbiter_status_out
);

    localparam int IDX_W  = $clog2(NUM_REQUESTERS);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    logic                                   enabled_q;
    logic [IDX_W-1:0]                       rr_ptr_q;
    logic [NUM_REQUESTERS-1:0][OUT_W-1:0]   outstanding_q, outstanding_d;
    CommandBufferLine                       command_q;
    ResponseBufferLine [NUM_REQUESTERS-1:0] response_q;
    logic                                   idle_q;
    logic [NUM_REQUESTERS-1:0]              error_q;

    CommandBufferLine [NUM_REQUESTERS-1:0]  fifo_head;
    logic [NUM_REQUESTERS-1:0][FCNT_W-1:0]  fifo_count;
    logic [NUM_REQUESTERS-1:0]              fifo_overflow;
    logic [NUM_REQUESTERS-1:0]              eligible, pop, unmatched;
    logic                                   grant_valid, idle_d;
    logic [IDX_W-1:0]                       winner, resp_idx;
    logic                                   unused_status_bits;

    assign unused_status_bits = &{1'b0, command_buffer_status_in.full, command_buffer_status_in.empty};

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_fifo
        cu_read_command_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock        (clock),
            .rstn         (rstn),
            .push_in      (command_in[i].valid),
            .data_in      (command_in[i]),
            .pop_in       (pop[i]),
            .data_out     (fifo_head[i]),
            .count_out    (fifo_count[i]),
            .status_out   (requester_status_out[i]),
            .overflow_out (fifo_overflow[i])
        );
    end

    // A requester may be granted when it has a queued command and room in its in-flight budget.
    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            eligible[i] = (fifo_count[i] != '0) && (outstanding_q[i] < OUT_W'(MAX_OUTSTANDING));
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        winner      = '0;
        if (enabled_q && !command_buffer_status_in.alfull) begin
            for (int k = 1; k <= NUM_REQUESTERS; k++) begin
                cand = rr_ptr_q + IDX_W'(k);
                if (!grant_valid && eligible[cand]) begin
                    grant_valid = 1'b1;
                    winner      = cand;
                end
            end
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            pop[i] = grant_valid && (winner == IDX_W'(i));
        end
    end

    assign resp_idx = IDX_W'(cu_id_to_requester(response_in.cu_id, NUM_REQUESTERS));

    // In-flight counter update; a grant and a response to the same requester cancel out.
    always_comb begin
        idle_d = 1'b1;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            logic dec;
            dec              = response_in.valid && (resp_idx == IDX_W'(i));
            outstanding_d[i] = outstanding_q[i];
            unmatched[i]     = 1'b0;
            if (pop[i] && !dec) begin
                outstanding_d[i] = outstanding_q[i] + OUT_W'(1);
            end else if (dec && !pop[i]) begin
                if (outstanding_q[i] == '0) unmatched[i] = 1'b1;
                else                        outstanding_d[i] = outstanding_q[i] - OUT_W'(1);
            end
            if ((fifo_count[i] != '0) || (outstanding_q[i] != '0)) idle_d = 1'b0;
        end
    end

    // Registered enable, arbitration state, counters and all registered outputs.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q     <= 1'b0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            command_q     <= '0;
            response_q    <= '0;
            idle_q        <= 1'b1;
            error_q       <= '0;
        end else begin
            enabled_q     <= enabled_in;
            outstanding_q <= outstanding_d;
            error_q       <= error_q | fifo_overflow | unmatched;
            idle_q        <= idle_d;
            if (grant_valid) begin
                rr_ptr_q        <= winner;
                command_q       <= fifo_head[winner];
                command_q.valid <= 1'b1;
            end else begin
                command_q <= '0;
            end
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                response_q[i] <= (response_in.valid && (resp_idx == IDX_W'(i))) ? response_in : '0;
            end
        end
    end

    // Debug view of the counters, truncated to the package-sized slots.
    always_comb begin
        arbiter_status_out        = '0;
        arbiter_status_out.rr_ptr = READ_IDX_W'(rr_ptr_q);
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (i < NUM_READ_REQUESTERS) begin
                arbiter_status_out.outstanding[i] = READ_CNT_W'(outstanding_q[i]);
            end
        end
    end

    assign command_out          = command_q;
    assign response_out         = response_q;
    assign outstanding_idle_out = idle_q;
    assign error_out            = error_q;

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Bench for cu_read_command_arbiter: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cu_read_command_arbiter;
    import cu_read_command_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int MAXO  = 16;

    logic                        clock = 1'b0;
    logic                        rstn  = 1'b1;
    logic                        enabled_in = 1'b0;
    CommandBufferLine  [N-1:0]   command_in = '0;
    BufferStatus                 command_buffer_status_in = '0;
    ResponseBufferLine           response_in = '0;
    CommandBufferLine            command_out;
    BufferStatus       [N-1:0]   requester_status_out;
    ResponseBufferLine [N-1:0]   response_out;
    logic                        outstanding_idle_out;
    logic [N-1:0]                error_out;
    ReadArbiterStatus            arbiter_status_out;

    int checks   = 0;
    int failures = 0;
    logic model_on = 1'b0;

    cu_read_command_arbiter #(.NUM_REQUESTERS(N), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clock                    (clock),
        .rstn                     (rstn),
        .enabled_in               (enabled_in),
        .command_in               (command_in),
        .command_buffer_status_in (command_buffer_status_in),
        .response_in              (response_in),
        .command_out              (command_out),
        .requester_status_out     (requester_status_out),
        .response_out             (response_out),
        .outstanding_idle_out     (outstanding_idle_out),
        .error_out                (error_out),
        .arbiter_status_out       (arbiter_status_out)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    CommandBufferLine  m_fifo [N][$];
    int                m_outst [N];
    int                m_rr;
    logic              m_en;
    CommandBufferLine  m_cmd;
    ResponseBufferLine m_resp [N];
    logic [N-1:0]      m_err;
    logic              m_idle;
    int                m_w, m_j;
    bit                m_grant, m_all_idle;
    bit [N-1:0]        m_popped;

    always @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                m_fifo[i].delete();
                m_outst[i] = 0;
                m_resp[i]  = '0;
            end
            m_rr = 0; m_en = 1'b0; m_cmd = '0; m_err = '0; m_idle = 1'b1;
        end else begin
            m_all_idle = 1;
            for (int i = 0; i < N; i++)
                if (m_fifo[i].size() != 0 || m_outst[i] != 0) m_all_idle = 0;
            m_grant = 0; m_w = 0; m_popped = '0;
            if (m_en && !command_buffer_status_in.alfull) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!m_grant && m_fifo[c].size() > 0 && m_outst[c] < MAXO) begin
                        m_grant = 1; m_w = c;
                    end
                end
            end
            if (m_grant) begin
                m_cmd = m_fifo[m_w].pop_front();
                m_cmd.valid = 1'b1;
                m_outst[m_w]++;
                m_rr = m_w;
                m_popped[m_w] = 1'b1;
            end else begin
                m_cmd = '0;
            end
            for (int i = 0; i < N; i++) m_resp[i] = '0;
            if (response_in.valid) begin
                m_j = int'(response_in.cu_id) % N;
                m_resp[m_j] = response_in;
                if (m_popped[m_j])        m_outst[m_j]--;
                else if (m_outst[m_j] == 0) m_err[m_j] = 1'b1;
                else                       m_outst[m_j]--;
            end
            for (int i = 0; i < N; i++) begin
                if (command_in[i].valid) begin
                    if (m_fifo[i].size() < DEPTH) m_fifo[i].push_back(command_in[i]);
                    else                          m_err[i] = 1'b1;
                end
            end
            m_idle = m_all_idle;
            m_en   = enabled_in;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_on) begin
            BufferStatus es;
            check("cmd_out", 64'(command_out), 64'(m_cmd));
            for (int i = 0; i < N; i++) begin
                int sz;
                sz = m_fifo[i].size();
                es.alfull = (sz >= DEPTH - 2);
                es.full   = (sz == DEPTH);
                es.empty  = (sz == 0);
                check($sformatf("resp_out[%0d]", i), 64'(response_out[i]), 64'(m_resp[i]));
                check($sformatf("status[%0d]", i), 64'(requester_status_out[i]), 64'(es));
                check($sformatf("outstanding[%0d]", i), 64'(arbiter_status_out.outstanding[i]), 64'(m_outst[i]));
            end
            check("error_out", 64'(error_out), 64'(m_err));
            check("idle_out", 64'(outstanding_idle_out), 64'(m_idle));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        command_in  = '0;
        response_in = '0;
    endtask

    function automatic CommandBufferLine mk_cmd(input int idx, input int tag);
        CommandBufferLine c;
        c.valid   = 1'b1;
        c.cu_id   = CU_ID_DATA_READ + 8'(idx);
        c.tag     = 8'(tag);
        c.address = $urandom;
        return c;
    endfunction

    function automatic ResponseBufferLine mk_resp(input int idx, input int tag);
        ResponseBufferLine r;
        r.valid    = 1'b1;
        r.cu_id    = CU_ID_DATA_READ + 8'(idx);
        r.tag      = 8'(tag);
        r.response = 2'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic do_reset();
        #2 rstn = 1'b0;
        clear_inputs();
        enabled_in = 1'b0;
        command_buffer_status_in = '0;
        repeat (2) @(posedge clock);
        #1 rstn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] exp_q [$];

    initial begin
        int gaps, grants, pushed1, pushed0, pushed2, valids;
        bit started;

        #1 rstn = 1'b0;
        model_on = 1'b1;
        #1;
        check("rst_cmd_out", 64'(command_out), 64'(0));
        check("rst_idle", 64'(outstanding_idle_out), 64'(1));
        check("rst_status0", 64'(requester_status_out[0]), 64'(3'b001));
        check("rst_error", 64'(error_out), 64'(0));
        repeat (3) @(posedge clock);
        #1 rstn = 1'b1;

        // Single requester, three commands back to back.
        enabled_in = 1'b1;
        tick();
        for (int t = 0; t < 6; t++) begin
            command_in[0] = (t < 3) ? mk_cmd(0, t) : '0;
            tick();
            check($sformatf("t1_valid_%0d", t), 64'(command_out.valid), 64'((t >= 1 && t <= 3) ? 1 : 0));
            if (t >= 1 && t <= 3) check($sformatf("t1_tag_%0d", t), 64'(command_out.tag), 64'(t - 1));
        end
        check("t1_outstanding0", 64'(arbiter_status_out.outstanding[0]), 64'(3));
        for (int r = 0; r < 3; r++) begin
            response_in = mk_resp(0, r);
            tick();
        end
        response_in = '0;
        check("t1_idle_lag", 64'(outstanding_idle_out), 64'(0));
        tick();
        check("t1_idle", 64'(outstanding_idle_out), 64'(1));

        // Round robin with all four requesters backlogged.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) command_in[i] = mk_cmd(i, k);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        end
        enabled_in = 1'b1;
        gaps = 0; grants = 0; started = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (command_out.valid) begin
                started = 1;
                grants++;
                if (exp_q.size() == 0) check("rr_extra_grant", 64'(1), 64'(0));
                else check($sformatf("rr_order_%0d", grants), 64'(command_out.cu_id[1:0]), 64'(exp_q.pop_front()));
            end else if (started && exp_q.size() != 0) begin
                gaps++;
            end
        end
        check("rr_grants", 64'(grants), 64'(12));
        check("rr_gaps", 64'(gaps), 64'(0));

        // Downstream almost-full with every FIFO full.
        do_reset();
        enabled_in = 1'b1;
        command_buffer_status_in.alfull = 1'b1;
        valids = 0;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) command_in[i] = (t < 4) ? mk_cmd(i, t) : '0;
            tick();
            if (command_out.valid) valids++;
        end
        check("alfull_no_grants", 64'(valids), 64'(0));
        for (int i = 0; i < N; i++) check($sformatf("alfull_full_%0d", i), 64'(requester_status_out[i].full), 64'(1));
        command_in[2] = mk_cmd(2, 9);
        tick();
        clear_inputs();
        check("overflow_error", 64'(error_out), 64'(4'b0100));
        check("overflow_still_full", 64'(requester_status_out[2].full), 64'(1));
        command_buffer_status_in.alfull = 1'b0;
        repeat (30) tick();

        // Requester 1 hits its in-flight cap while others keep flowing.
        do_reset();
        enabled_in = 1'b1;
        pushed0 = 0; pushed1 = 0; pushed2 = 0;
        for (int t = 0; t < 90; t++) begin
            command_in[1] = (pushed1 < 17 && !requester_status_out[1].full) ? mk_cmd(1, pushed1) : '0;
            command_in[0] = (pushed0 < 5 && !requester_status_out[0].full) ? mk_cmd(0, pushed0) : '0;
            command_in[2] = (pushed2 < 5 && !requester_status_out[2].full) ? mk_cmd(2, pushed2) : '0;
            if (command_in[1].valid) pushed1++;
            if (command_in[0].valid) pushed0++;
            if (command_in[2].valid) pushed2++;
            tick();
        end
        clear_inputs();
        tick();
        check("cap_outstanding1", 64'(arbiter_status_out.outstanding[1]), 64'(16));
        check("cap_queued1", 64'(requester_status_out[1].empty), 64'(0));
        check("cap_others0", 64'(arbiter_status_out.outstanding[0]), 64'(5));
        check("cap_others2", 64'(arbiter_status_out.outstanding[2]), 64'(5));
        response_in = mk_resp(1, 0);
        tick();
        response_in = '0;
        check("cap_release_wait", 64'(command_out.valid), 64'(0));
        tick();
        check("cap_release_valid", 64'(command_out.valid), 64'(1));
        check("cap_release_tag", 64'(command_out.tag), 64'(16));
        check("cap_release_idx", 64'(command_out.cu_id[1:0]), 64'(1));

        // Unmatched response on requester 3.
        do_reset();
        response_in = mk_resp(3, 8'h5A);
        tick();
        response_in = '0;
        check("unmatched_valid", 64'(response_out[3].valid), 64'(1));
        check("unmatched_tag", 64'(response_out[3].tag), 64'(8'h5A));
        check("unmatched_others", 64'({response_out[0], response_out[1], response_out[2]}), 64'(0));
        check("unmatched_error", 64'(error_out), 64'(4'b1000));
        check("unmatched_count", 64'(arbiter_status_out.outstanding[3]), 64'(0));

        // Reset in the middle of traffic with two commands queued.
        do_reset();
        enabled_in = 1'b1;
        command_buffer_status_in.alfull = 1'b1;
        for (int t = 0; t < 2; t++) begin
            command_in[0] = mk_cmd(0, t);
            tick();
        end
        clear_inputs();
        response_in = mk_resp(3, 1);
        tick();
        response_in = '0;
        #1 rstn = 1'b0;
        #1;
        check("midrst_resp", 64'(response_out[3]), 64'(0));
        check("midrst_error", 64'(error_out), 64'(0));
        check("midrst_empty0", 64'(requester_status_out[0]), 64'(3'b001));
        check("midrst_idle", 64'(outstanding_idle_out), 64'(1));
        check("midrst_cmd", 64'(command_out), 64'(0));
        command_buffer_status_in.alfull = 1'b0;
        @(posedge clock);
        #1 rstn = 1'b1;
        valids = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (command_out.valid) valids++;
        end
        check("midrst_no_issue", 64'(valids), 64'(0));

        // Random traffic against the model.
        do_reset();
        for (int t = 0; t < 2500; t++) begin
            enabled_in = ($urandom_range(0, 9) != 0);
            command_buffer_status_in.alfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0 && (!requester_status_out[i].full || $urandom_range(0, 199) == 0))
                    command_in[i] = mk_cmd(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : i, t);
                else
                    command_in[i] = '0;
            end
            response_in = '0;
            if ($urandom_range(0, 1) == 0) begin
                int j;
                j = $urandom_range(0, N - 1);
                if (m_outst[j] > 0) response_in = mk_resp(j, t);
            end
            tick();
        end
        clear_inputs();
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
